// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I load/store funct3
// encodings and the arbiter FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_align_check.sv
// Flags a load/store whose funct3 is not a legal RV32I encoding or whose
// address is not naturally aligned for its access size.
module dmem_align_check
  import dmem_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       wr_en_i,
  input  logic [1:0] addr_lsb_i,
  output logic       illegal_o
);

  always_comb begin
    illegal_o = 1'b1;
    if (wr_en_i) begin
      unique case (funct3_i)
        F3_SB:   illegal_o = 1'b0;
        F3_SH:   illegal_o = addr_lsb_i[0];
        F3_SW:   illegal_o = |addr_lsb_i;
        default: illegal_o = 1'b1;
      endcase
    end else begin
      unique case (funct3_i)
        F3_LB, F3_LBU: illegal_o = 1'b0;
        F3_LH, F3_LHU: illegal_o = addr_lsb_i[0];
        F3_LW:         illegal_o = |addr_lsb_i;
        default:       illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> RESP, one every three cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    req_valid_i,
  output logic [1:0]                    req_ready_o,
  input  logic [1:0]                    req_wr_en_i,
  input  logic [1:0][2:0]               req_funct3_i,
  input  logic [1:0][ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0]    req_wdata_i,
  output logic [1:0]                    resp_valid_o,
  output logic                          resp_err_o,
  output logic [DATA_WIDTH-1:0]         resp_rdata_o,
  output logic                          mem_wr_en_o,
  output logic [2:0]                    mem_funct3_o,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  state_e                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     wr_en_q, wr_en_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic gnt_idx;
  logic accept;
  logic illegal;

  // grant_q doubles as the round-robin history: on contention the other side wins.
  assign gnt_idx = (req_valid_i == 2'b11) ? ~grant_q : req_valid_i[1];
  assign accept  = rst_ni && (state_q == IDLE) && (|req_valid_i);

  dmem_align_check u_align_check (
    .funct3_i   (funct3_q),
    .wr_en_i    (wr_en_q),
    .addr_lsb_i (addr_q[1:0]),
    .illegal_o  (illegal)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    wr_en_d  = wr_en_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = ACCESS;
          grant_d  = gnt_idx;
          wr_en_d  = req_wr_en_i[gnt_idx];
          funct3_d = req_funct3_i[gnt_idx];
          addr_d   = req_addr_i[gnt_idx];
          wdata_d  = req_wdata_i[gnt_idx];
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = (!wr_en_q && !illegal) ? mem_rdata_i : '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      wr_en_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_en_q  <= wr_en_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // The memory-side payload comes straight from the latched request, so it
  // holds its last value outside ACCESS; only the write strobe is state-gated.
  assign req_ready_o  = accept ? (2'b01 << gnt_idx) : 2'b00;
  assign mem_wr_en_o  = (state_q == ACCESS) && wr_en_q && !illegal;
  assign mem_funct3_o = funct3_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign resp_valid_o = (state_q == RESP) ? (2'b01 << grant_q) : 2'b00;
  assign resp_err_o   = (state_q == RESP) && illegal;
  assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single transactions, legality cases,
// reset during a store, and round-robin under continuous contention.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           req_valid, req_wr_en, req_ready, resp_valid;
  logic [1:0][2:0]      req_funct3;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][DW-1:0]   req_wdata;
  logic                 resp_err, mem_wr_en;
  logic [DW-1:0]        resp_rdata, mem_wdata, mem_rdata;
  logic [2:0]           mem_funct3;
  logic [AW-1:0]        mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wr_en_i  (req_wr_en),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_err_o   (resp_err),
    .resp_rdata_o (resp_rdata),
    .mem_wr_en_o  (mem_wr_en),
    .mem_funct3_o (mem_funct3),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [2:0] f3,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_valid[idx]  = 1'b1;
    req_wr_en[idx]  = wr;
    req_funct3[idx] = f3;
    req_addr[idx]   = a;
    req_wdata[idx]  = wd;
  endtask

  // One complete transaction from a single requester, checked at T, T+1, T+2.
  task automatic run_txn(input string name, input int idx, input logic wr, input logic [2:0] f3,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] md, input logic exp_err);
    logic [1:0]    onehot;
    logic [DW-1:0] exp_rdata;
    onehot    = (idx == 0) ? 2'b01 : 2'b10;
    exp_rdata = (wr || exp_err) ? '0 : md;
    @(negedge clk);
    req_valid = 2'b00;
    set_req(idx, wr, f3, a, wd);
    mem_rdata = md;
    #1;
    chk({name, ".ready_T"}, req_ready, onehot);
    chk({name, ".wr_T"}, mem_wr_en, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk({name, ".ready_T1"}, req_ready, 2'b00);
    chk({name, ".addr_T1"}, mem_addr, a);
    chk({name, ".f3_T1"}, mem_funct3, f3);
    chk({name, ".wr_T1"}, mem_wr_en, wr && !exp_err);
    if (wr) chk({name, ".wdata_T1"}, mem_wdata, wd);
    chk({name, ".rv_T1"}, resp_valid, 2'b00);
    @(negedge clk);
    #1;
    chk({name, ".rv_T2"}, resp_valid, onehot);
    chk({name, ".err_T2"}, resp_err, exp_err);
    chk({name, ".rdata_T2"}, resp_rdata, exp_rdata);
    chk({name, ".wr_T2"}, mem_wr_en, 1'b0);
    chk({name, ".addr_hold_T2"}, mem_addr, a);
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 2'b00;
    req_wr_en  = 2'b00;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    #2 rst_n = 1'b0;

    // Reset state, with a request pending that must not be acknowledged.
    @(negedge clk);
    set_req(0, 1'b0, 3'b010, 32'h0001_0000, '0);
    #1;
    chk("rst.ready", req_ready, 2'b00);
    chk("rst.rv", resp_valid, 2'b00);
    chk("rst.err", resp_err, 1'b0);
    chk("rst.rdata", resp_rdata, '0);
    chk("rst.wr", mem_wr_en, 1'b0);
    chk("rst.addr", mem_addr, '0);
    chk("rst.f3", mem_funct3, 3'b000);
    chk("rst.wdata", mem_wdata, '0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("lw_core",   0, 1'b0, 3'b010, 32'h0001_0000, '0,           32'hDEAD_BEEF, 1'b0);
    run_txn("sb_core",   0, 1'b1, 3'b000, 32'h0001_0003, 32'h0000_00A5, 32'h5555_5555, 1'b0);
    run_txn("sw_mis",    1, 1'b1, 3'b010, 32'h0001_0002, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1);
    run_txn("ld_f3_111", 0, 1'b0, 3'b111, 32'h0001_0000, '0,           32'h1234_5678, 1'b1);
    run_txn("lh_mis",    1, 1'b0, 3'b001, 32'h0001_0001, '0,           32'h0000_7777, 1'b1);
    run_txn("lhu_ok",    1, 1'b0, 3'b101, 32'h0001_0002, '0,           32'h0000_BEEF, 1'b0);
    run_txn("st_f3_011", 0, 1'b1, 3'b011, 32'h0001_0000, 32'h0BAD_0BAD, 32'h0,        1'b1);
    run_txn("lbu_ok",    0, 1'b0, 3'b100, 32'h0001_0003, '0,           32'h0000_00A5, 1'b0);
    run_txn("sh_ok",     1, 1'b1, 3'b001, 32'h0001_0006, 32'h0000_BEEF, 32'h0,        1'b0);
    run_txn("lw_mis",    0, 1'b0, 3'b010, 32'h0001_0001, '0,           32'hCAFE_CAFE, 1'b1);

    // Last grant went to requester 0: reset must restore requester-0 priority.
    @(negedge clk);
    req_valid = 2'b00;
    set_req(0, 1'b1, 3'b010, 32'h0002_0000, 32'hCAFE_F00D);
    #1;
    chk("rstacc.ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rstacc.wr_before", mem_wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstacc.wr_after", mem_wr_en, 1'b0);
    chk("rstacc.rv_now", resp_valid, 2'b00);
    @(negedge clk);
    #1;
    chk("rstacc.rv_next", resp_valid, 2'b00);
    chk("rstacc.addr_cleared", mem_addr, '0);

    // Continuous contention right from reset release: grants alternate 0,1,0,1.
    for (int k = 0; k < 12; k++) begin
      logic [1:0] g_exp;
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        rst_n = 1'b1;
        set_req(0, 1'b0, 3'b010, 32'h0000_0100, '0);
        set_req(1, 1'b0, 3'b010, 32'h0000_0204, '0);
        mem_rdata = 32'h0000_0042;
      end
      #1;
      g_exp = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr.ready_%0d", k), req_ready, (k % 3 == 0) ? g_exp : 2'b00);
      chk($sformatf("rr.rv_%0d", k), resp_valid, (k % 3 == 2) ? g_exp : 2'b00);
      if (k % 3 == 1)
        chk($sformatf("rr.addr_%0d", k), mem_addr,
            (g_exp == 2'b01) ? 32'h0000_0100 : 32'h0000_0204);
    end
    req_valid = 2'b00;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, sets the byte-address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, sets the data width on all ports.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 req_valid_i  input  [1:0]  per-requester request valid; index 0 = core LSU, index 1 = loader/debug.
REQ-006 req_ready_o  output  [1:0]  per-requester request accepted this cycle.
REQ-007 req_wr_en_i  input  [1:0]  per-requester store (1) or load (0).
REQ-008 req_funct3_i  input  2x3  per-requester RV32I load/store funct3.
REQ-009 req_addr_i  input  2xADDRESS_WIDTH  per-requester byte address.
REQ-010 req_wdata_i  input  2xDATA_WIDTH  per-requester store data.
REQ-011 resp_valid_o  output  [1:0]  one-cycle response pulse to the granted requester.
REQ-012 resp_err_o  output  1  the response carries a misalign or illegal-funct3 error.
REQ-013 resp_rdata_o  output  DATA_WIDTH  registered load data; zero for stores and errors.
REQ-014 mem_wr_en_o  output  1  data memory write enable.
REQ-015 mem_funct3_o  output  3  data memory funct3.
REQ-016 mem_addr_o  output  ADDRESS_WIDTH  data memory address.
REQ-017 mem_wdata_o  output  DATA_WIDTH  data memory write data.
REQ-018 mem_rdata_i  input  DATA_WIDTH  combinational read data from the data memory.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP, with IDLE -> ACCESS on acceptance, ACCESS -> RESP unconditionally and RESP -> IDLE unconditionally.
REQ-020 req_ready_o SHALL be nonzero only in IDLE, and at most one bit SHALL be set per cycle.
REQ-021 In IDLE with one valid requester, that requester SHALL be granted.
REQ-022 In IDLE with both requesters valid, the requester not granted last SHALL be granted (round robin); after reset, requester 0 SHALL win.
REQ-023 On acceptance (valid & ready) the arbiter SHALL latch wr_en, funct3, addr, wdata and the grant index.
REQ-024 In ACCESS, mem_* outputs SHALL present the latched request; mem_wr_en_o SHALL be high for exactly this one cycle on a legal store.
REQ-025 In ACCESS, mem_rdata_i SHALL be captured into resp_rdata_o on a legal load.
REQ-026 In RESP, resp_valid_o SHALL pulse for one cycle on the granted index, giving a fixed latency of acceptance edge + 2 cycles.
REQ-027 Outside ACCESS, mem_wr_en_o SHALL be 0 and mem_addr_o, mem_funct3_o and mem_wdata_o SHALL hold their last values.
REQ-028 A request SHALL be illegal when it is LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0, a load funct3 of 011, 110 or 111, or a store funct3 other than 000, 001 or 010.
REQ-029 An illegal request SHALL still traverse ACCESS, with mem_wr_en_o held at 0, and SHALL respond with resp_err_o=1 and resp_rdata_o=0.
REQ-030 Requests not accepted SHALL NOT be dropped; the requester SHALL hold valid and its payload until ready.
REQ-031 Back-to-back accesses SHALL sustain one transaction every 3 cycles.

Reset
REQ-032 While rst_ni=0, the FSM SHALL be IDLE, last-grant SHALL be 1 (so requester 0 wins first), and all outputs SHALL be 0.
REQ-033 Reset asserted in ACCESS or RESP SHALL abandon the transaction with no response; a write in ACCESS SHALL be suppressed if reset is asserted before the clock edge.
REQ-034 After release, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-035 A shared package dmem_pkg SHALL hold the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum.
REQ-036 The legality check SHALL be a sub-module, dmem_align_check (funct3, wr_en, addr[1:0] -> illegal).

Verification
REQ-037 Core LW at 0x10000, memory returning 0xDEADBEEF -> ready[0] at T, mem_addr_o=0x10000 at T+1, resp_valid_o[0] with resp_rdata_o=0xDEADBEEF at T+2, resp_err_o=0.
REQ-038 Both requesters valid continuously after reset -> grants alternate 0,1,0,1 every 3 cycles.
REQ-039 Loader SW at 0x10002 -> mem_wr_en_o never asserts; resp_valid_o[1] with resp_err_o=1 and resp_rdata_o=0.
REQ-040 Core SB of 0x000000A5 at 0x10003 -> exactly one cycle with mem_wr_en_o=1, mem_funct3_o=000, mem_wdata_o=0x000000A5.
REQ-041 rst_ni dropped during ACCESS of a SW -> mem_wr_en_o=0 immediately, no resp_valid_o, and after release the FSM is IDLE with requester 0 prioritised.
REQ-042 Load funct3=111 at 0x10000 -> resp_err_o=1, resp_rdata_o=0.
